// File: rtl/sfu_ctrl_pkg.sv
// Shared types and default widths for the SFU post-processing sequencer.
package sfu_ctrl_pkg;
  localparam int COL     = 8;
  localparam int ROW_BW  = 6;
  localparam int ADDR_BW = 11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/sfu_ctrl_cnt.sv
// Loadable up-counter with terminal compare and "one before terminal" compare.
module sfu_ctrl_cnt import sfu_ctrl_pkg::*; #(
  parameter int W = ROW_BW
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  input  logic [W-1:0] term,
  output logic [W-1:0] count,
  output logic         at_term,
  output logic         next_term
);
  always_ff @(posedge clk) begin
    if (reset)     count <= '0;
    else if (load) count <= load_val;
    else if (inc)  count <= count + W'(1);
  end

  assign at_term   = (count == term);
  // Lets the FSM leave a state in the same cycle the final increment happens.
  assign next_term = ((count + W'(1)) == term);
endmodule

// File: rtl/sfu_ctrl.sv
// Sequencer: pops OFIFO rows into the SFU lanes, counts masked returns and
// produces psum-memory write strobes/addresses until the tile is written back.
module sfu_ctrl import sfu_ctrl_pkg::*; #(
  parameter int NCOL    = COL,
  parameter int RBW     = ROW_BW,
  parameter int ABW     = ADDR_BW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [RBW-1:0]  n_rows,
  input  logic [ABW-1:0]  base_addr,
  input  logic [NCOL-1:0] col_mask,
  input  logic            ofifo_valid,
  output logic            ofifo_rd,
  output logic [NCOL-1:0] sfu_valid_in,
  input  logic [NCOL-1:0] sfu_valid_out,
  output logic            mem_wr,
  output logic [ABW-1:0]  mem_addr,
  output logic            busy,
  output logic            done,
  output logic            err
);
  state_t          state, state_n;
  logic [RBW-1:0]  n_rows_q;
  logic [ABW-1:0]  base_addr_q;
  logic [NCOL-1:0] col_mask_q;
  logic [RBW-1:0]  issued, written;
  logic            iss_at, iss_next, wr_at, wr_next;
  logic            accept, active;
  logic [NCOL-1:0] ret;

  assign accept = (state == S_IDLE) && start;
  assign active = (state == S_ISSUE) || (state == S_DRAIN);
  assign ret    = sfu_valid_out & col_mask_q;

  sfu_ctrl_cnt #(.W(RBW)) u_issued (
    .clk(clk), .reset(reset), .load(accept), .load_val('0), .inc(ofifo_rd),
    .term(n_rows_q), .count(issued), .at_term(iss_at), .next_term(iss_next)
  );

  sfu_ctrl_cnt #(.W(RBW)) u_written (
    .clk(clk), .reset(reset), .load(accept), .load_val('0), .inc(mem_wr),
    .term(n_rows_q), .count(written), .at_term(wr_at), .next_term(wr_next)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (start) state_n = (n_rows != '0) ? S_ISSUE : S_DONE;
      S_ISSUE: if (ofifo_rd && iss_next) state_n = S_DRAIN;
      // Completion is seen in the cycle of the last write so done follows it directly.
      S_DRAIN: if (wr_at || (mem_wr && wr_next)) state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    ofifo_rd = 1'b0;
    mem_wr   = 1'b0;
    busy     = (state != S_IDLE);
    done     = (state == S_DONE);
    if (state == S_ISSUE) ofifo_rd = ofifo_valid && !iss_at;
    if (active)           mem_wr   = |ret;
  end

  assign mem_addr = base_addr_q + ABW'(written);

  always_ff @(posedge clk) begin
    if (reset) begin
      n_rows_q     <= '0;
      base_addr_q  <= '0;
      col_mask_q   <= '0;
      sfu_valid_in <= '0;
      err          <= 1'b0;
    end else begin
      sfu_valid_in <= ofifo_rd ? col_mask_q : '0;
      if (accept) begin
        n_rows_q    <= n_rows;
        base_addr_q <= base_addr;
        col_mask_q  <= col_mask;
        err         <= 1'b0;
      end else if (active && (ret != '0) && (ret != col_mask_q)) begin
        err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_sfu_ctrl.sv
// Directed bench for sfu_ctrl with a 2-cycle SFU lane model and an event monitor.
module tb_sfu_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  n_rows = '0;
  logic [10:0] base_addr = '0;
  logic [7:0]  col_mask = '0;
  logic        ofifo_valid = 1'b0;
  logic        ofifo_rd;
  logic [7:0]  sfu_valid_in;
  logic [7:0]  sfu_valid_out;
  logic        mem_wr;
  logic [10:0] mem_addr;
  logic        busy, done, err;

  sfu_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .n_rows(n_rows), .base_addr(base_addr),
    .col_mask(col_mask), .ofifo_valid(ofifo_valid), .ofifo_rd(ofifo_rd),
    .sfu_valid_in(sfu_valid_in), .sfu_valid_out(sfu_valid_out), .mem_wr(mem_wr),
    .mem_addr(mem_addr), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // OFIFO valid driver: 0 = low, 1 = held high, 2 = 1,0,0 repeating
  int vmode = 0;
  always @(posedge clk) begin : vdrv
    int ph;
    #2;
    case (vmode)
      1:       ofifo_valid = 1'b1;
      2:       ofifo_valid = (ph == 0);
      default: ofifo_valid = 1'b0;
    endcase
    ph = (ph >= 2) ? 0 : ph + 1;
  end

  // SFU model: fixed 2-cycle latency, optional corruption of one returned row
  logic [7:0] p1, p2;
  int ret_cnt;
  int bad_row = -1;
  logic [7:0] bad_val = '0;
  always @(posedge clk) begin
    if (reset) begin
      p1 <= '0; p2 <= '0; ret_cnt <= 0;
    end else begin
      p1 <= sfu_valid_in;
      p2 <= p1;
      if (start) ret_cnt <= 0;
      else if (p2 != '0) ret_cnt <= ret_cnt + 1;
    end
  end
  assign sfu_valid_out = (p2 != '0 && ret_cnt == bad_row) ? bad_val : p2;

  // Monitor: only ever appends / increments; tests take snapshots
  logic [7:0]  mask_cfg = '0;
  int          rd_q[$];
  logic [10:0] wa_q[$];
  int          wc_q[$];
  int          dn_q[$];
  int          n_badrd = 0, n_vin_bad = 0, n_vin = 0;
  logic        prev_rd = 1'b0;
  always @(negedge clk) begin
    if (reset) prev_rd = 1'b0;
    else begin
      if (ofifo_rd) begin
        rd_q.push_back(cyc);
        if (!ofifo_valid) n_badrd++;
      end
      if (mem_wr) begin
        wa_q.push_back(mem_addr);
        wc_q.push_back(cyc);
      end
      if (done) dn_q.push_back(cyc);
      if (sfu_valid_in !== (prev_rd ? mask_cfg : 8'h00)) n_vin_bad++;
      if (sfu_valid_in != '0) n_vin++;
      prev_rd = ofifo_rd;
    end
  end

  int rd0, wr0, dn0, br0, vb0, vn0, st_cyc;

  task automatic begin_tile(input logic [5:0] n, input logic [10:0] base, input logic [7:0] mask);
    rd0 = rd_q.size(); wr0 = wa_q.size(); dn0 = dn_q.size();
    br0 = n_badrd; vb0 = n_vin_bad; vn0 = n_vin;
    mask_cfg = mask;
    start = 1'b1; n_rows = n; base_addr = base; col_mask = mask;
    @(posedge clk); #1;
    start = 1'b0;
    st_cyc = cyc;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int k = 0;
    while (dn_q.size() == dn0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_done_seen"}, 32'(dn_q.size() > dn0), 1);
    @(posedge clk); #1;
    chk({tag, "_busy_after"}, 32'(busy), 0);
  endtask

  task automatic wait_rd(input int n, input int budget);
    int k = 0;
    while (rd_q.size() - rd0 < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("wait_rd_reached", 32'(rd_q.size() - rd0 >= n), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_outs", {ofifo_rd, mem_wr, done, err, sfu_valid_in}, 0);
    chk("rst_addr", 32'(mem_addr), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // basic tile
    vmode = 1;
    begin_tile(6'd4, 11'h100, 8'hFF);
    chk("basic_busy_t1", 32'(busy), 1);
    wait_done(40, "basic");
    chk("basic_rd_cnt", rd_q.size() - rd0, 4);
    chk("basic_rd_first", rd_q[rd0], st_cyc);
    chk("basic_rd_consec", rd_q[rd0+3] - rd_q[rd0], 3);
    chk("basic_vin_cnt", n_vin - vn0, 4);
    chk("basic_vin_align", n_vin_bad - vb0, 0);
    chk("basic_wr_cnt", wa_q.size() - wr0, 4);
    for (int i = 0; i < 4; i++) chk("basic_addr", 32'(wa_q[wr0+i]), 32'h100 + i);
    chk("basic_done_cnt", dn_q.size() - dn0, 1);
    chk("basic_done_lat", dn_q[dn0] - wc_q[wr0+3], 1);
    chk("basic_err", 32'(err), 0);

    // bubbles
    vmode = 2;
    @(posedge clk); #1;
    begin_tile(6'd3, 11'h020, 8'hFF);
    wait_done(60, "bub");
    chk("bub_rd_cnt", rd_q.size() - rd0, 3);
    chk("bub_rd_valid", n_badrd - br0, 0);
    chk("bub_wr_cnt", wa_q.size() - wr0, 3);
    chk("bub_done_lat", dn_q[dn0] - wc_q[wr0+2], 1);
    vmode = 1;

    // mask + misalignment on row 1
    bad_row = 1; bad_val = 8'h07;
    begin_tile(6'd4, 11'h040, 8'h0F);
    wait_done(40, "mask");
    chk("mask_vin_align", n_vin_bad - vb0, 0);
    chk("mask_wr_cnt", wa_q.size() - wr0, 4);
    chk("mask_err", 32'(err), 1);
    bad_row = -1;
    repeat (3) @(posedge clk); #1;
    chk("mask_err_sticky", 32'(err), 1);

    // n_rows = 0
    begin_tile(6'd0, 11'h055, 8'hFF);
    chk("zero_err_clr", 32'(err), 0);
    chk("zero_done_t1", 32'(done), 1);
    @(posedge clk); #1;
    chk("zero_busy_drop", 32'(busy), 0);
    repeat (3) @(posedge clk); #1;
    chk("zero_no_rd", rd_q.size() - rd0, 0);
    chk("zero_no_wr", wa_q.size() - wr0, 0);

    // address wrap
    begin_tile(6'd4, 11'h7FE, 8'hFF);
    wait_done(40, "wrap");
    chk("wrap_a0", 32'(wa_q[wr0]),   32'h7FE);
    chk("wrap_a1", 32'(wa_q[wr0+1]), 32'h7FF);
    chk("wrap_a2", 32'(wa_q[wr0+2]), 32'h000);
    chk("wrap_a3", 32'(wa_q[wr0+3]), 32'h001);

    // start while busy (during drain)
    begin_tile(6'd5, 11'h0C0, 8'hFF);
    wait_rd(5, 40);
    @(posedge clk); #1;
    start = 1'b1; n_rows = 6'd9; base_addr = 11'h300;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(40, "sbusy");
    repeat (4) @(posedge clk); #1;
    chk("sbusy_wr_cnt", wa_q.size() - wr0, 5);
    chk("sbusy_rd_cnt", rd_q.size() - rd0, 5);
    chk("sbusy_done_cnt", dn_q.size() - dn0, 1);
    chk("sbusy_last_addr", 32'(wa_q[wr0+4]), 32'h0C4);
    chk("sbusy_idle", 32'(busy), 0);

    // reset mid-tile
    begin_tile(6'd6, 11'h200, 8'hFF);
    wait_rd(2, 40);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_outs", {ofifo_rd, mem_wr, done, err, sfu_valid_in}, 0);
    chk("mrst_addr", 32'(mem_addr), 0);
    reset = 1'b0;
    repeat (5) @(posedge clk); #1;
    chk("mrst_no_done", dn_q.size() - dn0, 0);
    begin_tile(6'd2, 11'h010, 8'hFF);
    wait_done(40, "fresh");
    chk("fresh_wr_cnt", wa_q.size() - wr0, 2);
    chk("fresh_a0", 32'(wa_q[wr0]), 32'h010);
    chk("fresh_a1", 32'(wa_q[wr0+1]), 32'h011);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sfu_ctrl.md
# sfu_ctrl

Sequencer for the `sfu_array` post-processing stage. It pulls psum rows from the output FIFO and drives per-column `sfu_valid_in` under a column mask. It counts results returning on `sfu_valid_out` and generates write strobes and addresses into psum memory. It signals completion when every issued row has been written back, and sits between the OFIFO/psum memory and the SFU lanes.

## Interface
- `col`, 8, number of SFU lanes; width of the mask and valid vectors.
- `row_bw`, 6, width of the row-count and address counters; max rows per tile = 2^row_bw − 1.
- `addr_bw`, 11, width of the psum-memory write address.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high; clears all state.
- `start` in 1: one-cycle pulse; latches the config inputs; ignored unless the block is in IDLE.
- `n_rows` in `row_bw`: number of rows to process; sampled on `start`.
- `base_addr` in `addr_bw`: first write address; sampled on `start`.
- `col_mask` in `col`: enabled lanes; sampled on `start`.
- `ofifo_valid` in 1: OFIFO holds at least one full row.
- `ofifo_rd` out 1: pops one row; data is presented to `sfu_in` on the next cycle.
- `sfu_valid_in` out `col`: per-lane valid to `sfu_array`.
- `sfu_valid_out` in `col`: per-lane valid from `sfu_array`.
- `mem_wr` out 1: psum-memory write strobe, aligned with `sfu_out`.
- `mem_addr` out `addr_bw`: write address.
- `busy` out 1: high whenever the block is not in IDLE.
- `done` out 1: one-cycle pulse when a tile completes.
- `err` out 1: sticky lane-misalignment flag; cleared on `start` or `reset`.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- **IDLE**
  - On `start`: latch `n_rows`, `base_addr` and `col_mask`; clear `issued`, `written` and `err`.
  - Go to ISSUE if `n_rows` ≠ 0, otherwise go to DONE.
- **ISSUE**
  - Each cycle with `ofifo_valid`=1 and `issued` < `n_rows`: assert `ofifo_rd` and increment `issued`.
  - When `issued` reaches `n_rows` (after the increment), go to DRAIN on the next cycle.
  - `ofifo_rd` must never assert when `issued` = `n_rows`.
- **Issue pipeline**
  - `sfu_valid_in` is a register: it equals `col_mask` in the cycle after each `ofifo_rd`, otherwise all zeros.
  - Masked-off lanes never see valid.
- **Return path**
  - `mem_wr` = |(`sfu_valid_out` & `col_mask_q`), combinational, in ISSUE or DRAIN only.
  - `mem_addr` = `base_addr_q` + `written` (zero-extended, modulo 2^`addr_bw`).
  - `written` increments on each `mem_wr`.
- **Alignment check**
  - If `sfu_valid_out` & `col_mask_q` is neither all zeros nor equal to `col_mask_q`, set `err`.
  - A write is still counted in that case.
- **DRAIN**: when `written` = `n_rows_q` (including the cycle in which the last `mem_wr` occurs), go to DONE.
- **DONE**: assert `done` for one cycle, then return to IDLE.
- `start` while `busy` is ignored and has no effect on the latched config.
- Returns may overlap issues; ISSUE and DRAIN both count writes.
- Any `sfu_valid_out` seen in IDLE or DONE is ignored: no write, no error.

## Timing
- **Reset values**:
  - State = IDLE.
  - `ofifo_rd`, `sfu_valid_in`, `mem_wr`, `busy`, `done`, `err` = 0.
  - `mem_addr` = 0, because `base_addr_q` and `written` reset to 0.
- Reset mid-operation aborts the tile. No `done` pulse is emitted, and in-flight SFU results are dropped.
- **Latency**:
  - `start` at cycle t → `busy` = 1 at t+1.
  - First `ofifo_rd` no earlier than t+1.
  - `sfu_valid_in` follows `ofifo_rd` by exactly 1 cycle.
  - `mem_wr` is coincident with `sfu_valid_out`; the SFU latency is not encoded in this block.
- Throughput: one row per cycle when `ofifo_valid` is held high.
- `done` is asserted in the cycle after `written` reaches `n_rows_q`; `busy` drops one cycle after `done`.
- `n_rows` = 0: `start` at t → `done` at t+1, with no `ofifo_rd` and no `mem_wr`.

## Structure
- Shared package `sfu_ctrl_pkg` holds:
  - the state enum (IDLE/ISSUE/DRAIN/DONE);
  - default widths for `row_bw` and `addr_bw`.
- One natural sub-module: `sfu_ctrl_cnt`, a loadable up-counter with terminal-compare output. Instantiate it twice, once for `issued` and once for `written`.
- The top level instantiates `sfu_ctrl` alongside `sfu_array`. It wires `sfu_valid_in` and `sfu_valid_out` directly; the data path bypasses this block.

## Test plan
- **Basic tile**:
  - Stimulus: `col_mask` = 0xFF, `n_rows` = 4, `base_addr` = 0x100, `ofifo_valid` held high, 2-cycle SFU model.
  - Required: 4 consecutive `ofifo_rd`; `sfu_valid_in` = 0xFF for 4 cycles; `mem_addr` = 0x100–0x103; one `done`; `err` = 0.
- **Bubbles**:
  - Stimulus: `ofifo_valid` toggles 1,0,0,1,… with `n_rows` = 3.
  - Required: `ofifo_rd` only when `ofifo_valid` = 1; exactly 3 pops; `done` after the third write.
- **Mask plus misalignment**:
  - Stimulus: `col_mask` = 0x0F; the SFU model returns 0x07 on row 1.
  - Required: `sfu_valid_in` = 0x0F; lanes 4–7 never valid; `err` = 1 and stays sticky until the next `start`; all writes still counted.
- **Edge config**:
  - Stimulus 1: `n_rows` = 0.
    - Required: `done` at t+1; no `ofifo_rd` and no `mem_wr`.
  - Stimulus 2: `base_addr` = 0x7FE, `n_rows` = 4.
    - Required: addresses 0x7FE, 0x7FF, 0x000, 0x001.
- **Start while busy**:
  - Stimulus: a second `start` with `n_rows` = 9 during the DRAIN of a 5-row tile.
  - Required: ignored; exactly 5 writes and one `done`.
- **Reset mid-tile**:
  - Stimulus: `reset` after 2 of 6 rows.
  - Required: next cycle IDLE with all outputs 0, no `done`; a fresh `start` with `n_rows` = 2 completes normally.
